// File: rtl/aud_mix_seq.sv
// Time-multiplexed stereo mixer: sums NSRC sources, applies crossfeed and a
// ramped master gain, then saturates to DW bits once per accepted sample.
module aud_mix_seq #(
  parameter int unsigned NSRC      = 2,
  parameter int unsigned DW        = 16,
  parameter int unsigned RAMP_STEP = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [NSRC*DW-1:0]   src_l,
  input  logic [NSRC*DW-1:0]   src_r,
  input  logic [NSRC-1:0]      src_en,
  input  logic [4:0]           att,
  input  logic [1:0]           mix,
  output logic [DW-1:0]        out_l,
  output logic [DW-1:0]        out_r,
  output logic                 out_valid,
  output logic                 clip_l,
  output logic                 clip_r,
  output logic                 busy,
  output logic                 overrun
);

  localparam int unsigned KW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int unsigned AW = DW + $clog2(NSRC) + 1;
  localparam int unsigned XW = AW + 1;
  localparam int unsigned PW = XW + 10;
  localparam logic signed [9:0]    STEP    = 10'(RAMP_STEP);
  localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_XF, S_GAIN, S_OUT} state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [NSRC*DW-1:0]    snap_l_q, snap_l_d, snap_r_q, snap_r_d;
  logic [NSRC-1:0]       en_q, en_d;
  logic [1:0]            mix_q, mix_d;
  logic [8:0]            g_q, g_d;
  logic signed [AW-1:0]  acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [XW-1:0]  x_l_q, x_l_d, x_r_q, x_r_d;
  logic signed [PW-1:0]  p_l_q, p_l_d, p_r_q, p_r_d;
  logic [DW-1:0]         out_l_q, out_l_d, out_r_q, out_r_d;
  logic                  clip_l_q, clip_l_d, clip_r_q, clip_r_d;
  logic                  valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;

  logic [8:0]            tg;
  logic signed [9:0]     gdiff;
  logic signed [DW-1:0]  smp_l, smp_r;
  logic signed [PW-1:0]  prod_l, prod_r;

  // Gain target and distance from the current gain, plus the source under accumulation
  assign tg     = att[4] ? 9'd0 : 9'(9'd256 >> att[3:0]);
  assign gdiff  = $signed({1'b0, tg}) - $signed({1'b0, g_q});
  assign smp_l  = snap_l_q[32'(k_q) * DW +: DW];
  assign smp_r  = snap_r_q[32'(k_q) * DW +: DW];
  assign prod_l = PW'(x_l_q) * PW'($signed({1'b0, g_q}));
  assign prod_r = PW'(x_r_q) * PW'($signed({1'b0, g_q}));

  function automatic logic signed [XW-1:0] xfeed(input logic signed [AW-1:0] a,
                                                 input logic signed [AW-1:0] b,
                                                 input logic [1:0] m);
    logic signed [XW-1:0] ea, eb;
    ea = XW'(a);
    eb = XW'(b);
    case (m)
      2'd0:    xfeed = ea;
      2'd1:    xfeed = ea - (ea >>> 3) + (eb >>> 2);
      2'd2:    xfeed = ea - (ea >>> 2) + (eb >>> 1);
      default: xfeed = (ea >>> 1) + (eb >>> 1);
    endcase
  endfunction

  // Returns {clip, saturated sample}
  function automatic logic [DW:0] sat(input logic signed [PW-1:0] p);
    if (p > SAT_MAX)      sat = {1'b1, SAT_MAX[DW-1:0]};
    else if (p < SAT_MIN) sat = {1'b1, SAT_MIN[DW-1:0]};
    else                  sat = {1'b0, p[DW-1:0]};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      snap_l_q <= '0;
      snap_r_q <= '0;
      en_q     <= '0;
      mix_q    <= '0;
      g_q      <= '0;
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      x_l_q    <= '0;
      x_r_q    <= '0;
      p_l_q    <= '0;
      p_r_q    <= '0;
      out_l_q  <= '0;
      out_r_q  <= '0;
      clip_l_q <= 1'b0;
      clip_r_q <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      snap_l_q <= snap_l_d;
      snap_r_q <= snap_r_d;
      en_q     <= en_d;
      mix_q    <= mix_d;
      g_q      <= g_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      x_l_q    <= x_l_d;
      x_r_q    <= x_r_d;
      p_l_q    <= p_l_d;
      p_r_q    <= p_r_d;
      out_l_q  <= out_l_d;
      out_r_q  <= out_r_d;
      clip_l_q <= clip_l_d;
      clip_r_q <= clip_r_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    snap_l_d = snap_l_q;
    snap_r_d = snap_r_q;
    en_d     = en_q;
    mix_d    = mix_q;
    g_d      = g_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    x_l_d    = x_l_q;
    x_r_d    = x_r_q;
    p_l_d    = p_l_q;
    p_r_d    = p_r_q;
    out_l_d  = out_l_q;
    out_r_d  = out_r_q;
    clip_l_d = clip_l_q;
    clip_r_d = clip_r_q;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ce) begin
          snap_l_d = src_l;
          snap_r_d = src_r;
          en_d     = src_en;
          mix_d    = mix;
          acc_l_d  = '0;
          acc_r_d  = '0;
          k_d      = '0;
          // Ramp toward the target so volume changes never click
          if (gdiff > STEP)       g_d = g_q + 9'(RAMP_STEP);
          else if (gdiff < -STEP) g_d = g_q - 9'(RAMP_STEP);
          else                    g_d = tg;
          state_d  = S_ACC;
        end
      end
      S_ACC: begin
        if (en_q[k_q]) begin
          acc_l_d = acc_l_q + AW'(smp_l);
          acc_r_d = acc_r_q + AW'(smp_r);
        end
        if (k_q == KW'(NSRC - 1)) state_d = S_XF;
        else                      k_d = k_q + KW'(1);
      end
      S_XF: begin
        x_l_d   = xfeed(acc_l_q, acc_r_q, mix_q);
        x_r_d   = xfeed(acc_r_q, acc_l_q, mix_q);
        state_d = S_GAIN;
      end
      S_GAIN: begin
        p_l_d   = prod_l >>> 8;
        p_r_d   = prod_r >>> 8;
        state_d = S_OUT;
      end
      S_OUT: begin
        {clip_l_d, out_l_d} = sat(p_l_q);
        {clip_r_d, out_r_d} = sat(p_r_q);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ovr_d  = ovr_q | (ce & (state_q != S_IDLE));
    busy_d = (state_d != S_IDLE);
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign clip_l    = clip_l_q;
  assign clip_r    = clip_r_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_aud_mix_seq.sv
// Bench for aud_mix_seq: two instances (fast and slow gain ramp) checked every
// cycle against a sample-level model, plus hand-computed anchor values.
module tb_aud_mix_seq;
  localparam int NSRC = 2;
  localparam int DW   = 16;
  localparam int LAT  = NSRC + 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic ce = 1'b0;
  logic [NSRC*DW-1:0] src_l = '0, src_r = '0;
  logic [NSRC-1:0]    src_en = '0;
  logic [4:0]         att = '0;
  logic [1:0]         mix = '0;

  logic [DW-1:0] out_l_a, out_r_a, out_l_b, out_r_b;
  logic valid_a, clip_l_a, clip_r_a, busy_a, ovr_a;
  logic valid_b, clip_l_b, clip_r_b, busy_b, ovr_b;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aud_mix_seq #(.NSRC(NSRC), .DW(DW), .RAMP_STEP(256)) dut_a (
    .clk(clk), .reset_n(reset_n), .ce(ce), .src_l(src_l), .src_r(src_r),
    .src_en(src_en), .att(att), .mix(mix), .out_l(out_l_a), .out_r(out_r_a),
    .out_valid(valid_a), .clip_l(clip_l_a), .clip_r(clip_r_a), .busy(busy_a),
    .overrun(ovr_a));

  aud_mix_seq #(.NSRC(NSRC), .DW(DW), .RAMP_STEP(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .ce(ce), .src_l(src_l), .src_r(src_r),
    .src_en(src_en), .att(att), .mix(mix), .out_l(out_l_b), .out_r(out_r_b),
    .out_valid(valid_b), .clip_l(clip_l_b), .clip_r(clip_r_b), .busy(busy_b),
    .overrun(ovr_b));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- sample-level model ----------------
  int rem = 0;
  int g_a = 0, g_b = 0;
  logic m_valid = 1'b0, m_ovr = 1'b0;
  logic [DW-1:0] e_l_a = '0, e_r_a = '0, e_l_b = '0, e_r_b = '0;
  logic e_cl_a = 1'b0, e_cr_a = 1'b0, e_cl_b = 1'b0, e_cr_b = 1'b0;
  logic [DW-1:0] n_l_a, n_r_a, n_l_b, n_r_b;
  logic n_cl_a, n_cr_a, n_cl_b, n_cr_b;

  function automatic longint xf(input longint a, input longint b, input logic [1:0] m);
    case (m)
      2'd0:    return a;
      2'd1:    return a - (a >>> 3) + (b >>> 2);
      2'd2:    return a - (a >>> 2) + (b >>> 1);
      default: return (a >>> 1) + (b >>> 1);
    endcase
  endfunction

  function automatic int step(input int g, input int tg, input int rs);
    int d;
    d = tg - g;
    if (d <= rs && d >= -rs) return tg;
    return (d > 0) ? g + rs : g - rs;
  endfunction

  task automatic satm(input longint p, output logic [DW-1:0] o, output logic c);
    longint maxv, minv;
    maxv = (longint'(1) <<< (DW - 1)) - 1;
    minv = -maxv - 1;
    if (p > maxv)      begin o = maxv[DW-1:0]; c = 1'b1; end
    else if (p < minv) begin o = minv[DW-1:0]; c = 1'b1; end
    else               begin o = p[DW-1:0];    c = 1'b0; end
  endtask

  task automatic predict(input int g, output logic [DW-1:0] ol, output logic [DW-1:0] orr,
                         output logic cl, output logic cr);
    longint a, b;
    a = 0;
    b = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (src_en[i]) begin
        a += longint'($signed(src_l[i*DW +: DW]));
        b += longint'($signed(src_r[i*DW +: DW]));
      end
    end
    satm((xf(a, b, mix) * g) >>> 8, ol, cl);
    satm((xf(b, a, mix) * g) >>> 8, orr, cr);
  endtask

  initial begin
    int tg;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        rem = 0; m_valid = 1'b0; m_ovr = 1'b0; g_a = 0; g_b = 0;
        e_l_a = '0; e_r_a = '0; e_l_b = '0; e_r_b = '0;
        e_cl_a = 1'b0; e_cr_a = 1'b0; e_cl_b = 1'b0; e_cr_b = 1'b0;
      end else begin
        m_valid = 1'b0;
        if (rem > 0) begin
          if (ce) m_ovr = 1'b1;
          rem--;
          if (rem == 0) begin
            m_valid = 1'b1;
            e_l_a = n_l_a; e_r_a = n_r_a; e_cl_a = n_cl_a; e_cr_a = n_cr_a;
            e_l_b = n_l_b; e_r_b = n_r_b; e_cl_b = n_cl_b; e_cr_b = n_cr_b;
          end
        end else if (ce) begin
          tg  = att[4] ? 0 : (256 >> att[3:0]);
          g_a = step(g_a, tg, 256);
          g_b = step(g_b, tg, 1);
          predict(g_a, n_l_a, n_r_a, n_cl_a, n_cr_a);
          predict(g_b, n_l_b, n_r_b, n_cl_b, n_cr_b);
          rem = LAT;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("valid_a", valid_a, m_valid);
        check("valid_b", valid_b, m_valid);
        check("busy_a", busy_a, rem > 0);
        check("busy_b", busy_b, rem > 0);
        check("ovr_a", ovr_a, m_ovr);
        check("ovr_b", ovr_b, m_ovr);
        check("out_l_a", out_l_a, e_l_a);
        check("out_r_a", out_r_a, e_r_a);
        check("clip_a", {clip_l_a, clip_r_a}, {e_cl_a, e_cr_a});
        check("out_l_b", out_l_b, e_l_b);
        check("out_r_b", out_r_b, e_r_b);
        check("clip_b", {clip_l_b, clip_r_b}, {e_cl_b, e_cr_b});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setsrc(input int i, input logic [DW-1:0] l, input logic [DW-1:0] r);
    src_l[i*DW +: DW] = l;
    src_r[i*DW +: DW] = r;
  endtask

  // Pulses ce, scrambles sources after accept, returns cycles to out_valid
  task automatic run_sample(output int lat);
    logic [NSRC*DW-1:0] sl, sr;
    logic [NSRC-1:0] se;
    sl = src_l; sr = src_r; se = src_en;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    for (int i = 0; i < NSRC; i++) setsrc(i, DW'($urandom()), DW'($urandom()));
    src_en = NSRC'($urandom());
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (valid_a) begin
        lat = n;
        break;
      end
    end
    src_l = sl; src_r = sr; src_en = se;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int lat, cnt;
    logic [4:0] att_tab [5];
    att_tab[0] = 5'h00; att_tab[1] = 5'h01; att_tab[2] = 5'h03;
    att_tab[3] = 5'h10; att_tab[4] = 5'h02;

    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {out_l_a, out_r_a, out_l_b, out_r_b}, 64'h0);
    check("rst_flags", {valid_a, clip_l_a, clip_r_a, busy_a, ovr_a,
                        valid_b, clip_l_b, clip_r_b, busy_b, ovr_b}, 64'h0);
    reset_n = 1'b1;
    tick();

    // Latency and sum
    setsrc(0, 16'h1000, 16'h0000);
    setsrc(1, 16'h0800, 16'h0000);
    src_en = 2'b11; att = 5'h00; mix = 2'd0;
    run_sample(lat);
    check("latency", lat, LAT);
    check("sum_l", out_l_a, 16'h1800);
    check("sum_clip", clip_l_a, 1'b0);
    check("sum_l_slowramp", out_l_b, 16'h0018);

    // Saturation both polarities
    setsrc(0, 16'h4000, 16'h8000);
    setsrc(1, 16'h4000, 16'h8000);
    run_sample(lat);
    check("sat_l", {clip_l_a, out_l_a}, {1'b1, 16'h7FFF});
    check("sat_r", {clip_r_a, out_r_a}, {1'b1, 16'h8000});

    // Crossfeed
    setsrc(0, 16'h2000, 16'h0000);
    setsrc(1, 16'h1234, 16'h5678);
    src_en = 2'b01; mix = 2'd1;
    run_sample(lat);
    check("xf1_l", out_l_a, 16'h1C00);
    check("xf1_r", out_r_a, 16'h0800);
    mix = 2'd3;
    run_sample(lat);
    check("xf3_l", out_l_a, 16'h1000);
    check("xf3_r", out_r_a, 16'h1000);

    // Mixed patterns checked by the model only
    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < NSRC; i++) setsrc(i, DW'($urandom()), DW'($urandom()));
      src_en = NSRC'($urandom());
      mix = 2'($urandom_range(0, 3));
      att = att_tab[$urandom_range(0, 4)];
      run_sample(lat);
      check("latency_rand", lat, LAT);
    end

    // Overrun: second ce two cycles after accept is dropped
    att = 5'h00; mix = 2'd0; src_en = 2'b01;
    setsrc(0, 16'h0100, 16'h0200);
    ce = 1'b1; tick(); ce = 1'b0;
    tick();
    ce = 1'b1; tick(); ce = 1'b0;
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (valid_a) cnt++;
    end
    check("ovr_one_valid", cnt, 1);
    check("ovr_set", ovr_a, 1'b1);
    run_sample(lat);
    check("ovr_sticky", ovr_a, 1'b1);

    // Reset during accumulation
    setsrc(0, 16'h4000, 16'h0000);
    src_en = 2'b01; att = 5'h00; mix = 2'd0;
    ce = 1'b1; tick(); ce = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("midrst_out", {out_l_a, out_r_a, out_l_b, out_r_b}, 64'h0);
    check("midrst_flags", {valid_a, busy_a, ovr_a, clip_l_a, busy_b, ovr_b}, 64'h0);
    tick();
    reset_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (valid_a || valid_b) cnt++;
    end
    check("midrst_no_valid", cnt, 0);
    run_sample(lat);
    check("midrst_fadein_b", out_l_b, 16'h0040);
    check("midrst_fast_a", out_l_a, 16'h4000);

    // Slow gain ramp up, then mute ramp down
    reset_pulse();
    setsrc(0, 16'h4000, 16'h0000);
    src_en = 2'b01; att = 5'h00; mix = 2'd0;
    for (int i = 1; i <= 300; i++) begin
      run_sample(lat);
      if (i == 1)   check("ramp_1", out_l_b, 16'h0040);
      if (i == 2)   check("ramp_2", out_l_b, 16'h0080);
      if (i == 256) check("ramp_256", out_l_b, 16'h4000);
      if (i == 300) check("ramp_hold", out_l_b, 16'h4000);
    end
    att = 5'h10;
    for (int i = 1; i <= 258; i++) begin
      run_sample(lat);
      if (i == 1)   check("mute_1", out_l_b, 16'h3FC0);
      if (i == 128) check("mute_128", out_l_b, 16'h2000);
      if (i == 256) check("mute_256", out_l_b, 16'h0000);
      if (i == 258) check("mute_hold", out_l_b, 16'h0000);
    end
    check("mute_fast_a", out_l_a, 16'h0000);

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/aud_mix_seq.md
# aud_mix_seq

Parametrised, time-multiplexed stereo audio mixer for the audio output path. It sums NSRC stereo sources and applies stereo crossfeed. It then applies a click-free ramped master gain and saturates the result to DW bits. Outputs arrive once per sample strobe and feed the I2S, SPDIF and sigma-delta serialisers. It generalises the fixed two-input core/Linux mixer in three ways: arbitrary source count, width and ramped volume. It also adds overrun and clip reporting.

## Interface
Parameters:
- NSRC, 2: number of stereo sources, 1..16.
- DW, 16: sample width, signed two's complement, 8..24.
- RAMP_STEP, 1: maximum gain change per accepted sample, 1..256.

Ports:
- clk  in  1  system clock; single clock domain.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  sample strobe, one-cycle pulse.
- src_l  in  NSRC*DW  left samples; source i occupies bits [i*DW +: DW].
- src_r  in  NSRC*DW  right samples, same packing as src_l.
- src_en  in  NSRC  per-source enable; 0 means the source contributes 0.
- att  in  5  master attenuation; bit4 = mute, bits3:0 = shift.
- mix  in  2  crossfeed mode.
- out_l, out_r  out  DW  mixed, saturated samples.
- out_valid  out  1  one-cycle pulse when out_l/out_r update.
- clip_l, clip_r  out  1  saturation occurred on this output; valid with out_valid.
- busy  out  1  sequencer not idle.
- overrun  out  1  sticky; set when ce arrives while busy.

## Operation
- FSM states are IDLE, ACC, XF, GAIN and OUT.
- IDLE, ce=1:
  - snapshot src_l, src_r and src_en into internal registers;
  - clear both accumulators;
  - update the gain;
  - set index k=0;
  - go to ACC.
- ACC: each cycle, add sign-extended snapshot source k (if enabled) to acc_l and acc_r; k++. After source NSRC-1, go to XF.
- Accumulator width is AW = DW+ceil(log2(NSRC))+1. The accumulator never wraps.
- XF computes x_l from a=acc_l and b=acc_r; x_r is symmetric. All shifts are arithmetic (floor).
  - mix=0: x_l = a.
  - mix=1: x_l = a - (a>>>3) + (b>>>2).
  - mix=2: x_l = a - (a>>>2) + (b>>>1).
  - mix=3: x_l = (a>>>1) + (b>>>1), i.e. mono.
  - Intermediate width is AW+1.
- Target gain tg (9 bits, 256 = unity):
  - att[4]=1 gives tg = 0;
  - otherwise tg = 256 >> att[3:0].
- Gain update at sample accept:
  - if |tg - g| <= RAMP_STEP, then g = tg;
  - otherwise g moves toward tg by RAMP_STEP.
  - The updated g applies to the current sample.
  - att/mix are sampled only at accept.
- GAIN: p = (x * g) >>> 8, signed multiply with floor.
- OUT: saturate p to the DW signed range [-2^(DW-1), 2^(DW-1)-1].
  - Set clip_x = 1 if saturation occurred, else 0.
  - Register out_l/out_r and pulse out_valid.
  - Return to IDLE.
- Output hold: out_l, out_r, clip_l and clip_r hold their values until the next OUT.
- Reset: g resets to 0, so audio fades in from silence after reset.
- overrun:
  - set by ce while busy=1; that strobe is otherwise ignored (dropped);
  - cleared only by reset.

## Timing
- Accept happens on the ce cycle in IDLE; busy=1 from the next cycle.
- out_valid asserts NSRC+3 cycles after the accept edge; ACC takes NSRC cycles, XF, GAIN and OUT one each.
- busy deasserts the same cycle out_valid asserts. A ce in that cycle is accepted with no overrun, so the minimum ce spacing is NSRC+3 cycles.
- Source inputs may change any time after the accept cycle without affecting the sample in flight.
- Reset values:
  - 0: out_l, out_r, out_valid, clip_l, clip_r, busy, overrun, g;
  - FSM in IDLE.
- reset_n low mid-operation: the in-flight sample is abandoned, all outputs go to reset values immediately (async), and no out_valid is produced for it.
- Reset release: the first ce is accepted only once reset_n has been sampled high.

## Test plan
Default configuration: NSRC=2, DW=16, RAMP_STEP=256.
- Latency and sum:
  - stimulus: src0_l=0x1000, src1_l=0x0800, both enabled, att=0, mix=0, one ce;
  - required: out_valid exactly 5 cycles after accept, out_l=0x1800, clip_l=0.
- Saturation:
  - stimulus: src0_l=src1_l=0x4000, then src0_r=src1_r=0x8000;
  - required: out_l=0x7FFF with clip_l=1, out_r=0x8000 with clip_r=1.
- Crossfeed:
  - stimulus: src0_l=0x2000, src0_r=0 (src1 disabled), mix=1, then mix=3;
  - required: mix=1 gives out_l=0x1C00 and out_r=0x0800; mix=3 gives out_l=out_r=0x1000.
- Gain ramp (RAMP_STEP=1):
  - stimulus: after reset, att=0, src0_l=0x4000, repeated ce;
  - required: 1st out_l=0x0040, 256th out_l=0x4000 and it stays there;
  - then set att=5'h10: out_l steps down by 0x40 per sample, reaching 0 after 256 samples.
- Overrun:
  - stimulus: second ce 2 cycles after the first accept;
  - required: overrun=1 and exactly one out_valid; overrun stays 1 until reset.
- Reset mid-ACC:
  - stimulus: pull reset_n low during ACC;
  - required: immediate zero outputs and busy=0, no out_valid; the next sample after release uses g ramping from 0.
